// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared types and defaults for the uart transmit scheduler
package uart_sched_pkg;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} drain_state_t;

    localparam int DEFAULT_BYTE_CYCLES = 10851;
    localparam int DEFAULT_DEPTH       = 16;

endpackage

// File: rtl/uart_tx_scheduler_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; refuses push when full, pop when empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr;
    logic             rd;

    assign full  = level == LW'(DEPTH);
    assign empty = level == '0;
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(wr) - LW'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: arbitrates core/debug bytes into a FIFO and paces them to the uart core
// one frame apart, since the core has no busy flag of its own.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int BYTE_CYCLES = DEFAULT_BYTE_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   core_we,
    input  logic [7:0]             core_data,
    output logic                   core_stall,
    input  logic                   dbg_req,
    input  logic [7:0]             dbg_data,
    output logic                   dbg_ack,
    output logic                   uart_we,
    output logic [7:0]             uart_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy
);
    localparam int            CW     = $clog2(BYTE_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(BYTE_CYCLES - 2);

    drain_state_t  state;
    drain_state_t  state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          dbg_push;
    logic [7:0]    push_data;
    logic [7:0]    head;

    // core wins; debug only gets a slot when the core is not storing
    assign dbg_push   = dbg_req && !core_we && !full;
    assign push       = (core_we && !full) || dbg_push;
    assign push_data  = core_we ? core_data : dbg_data;
    assign core_stall = full;
    assign dbg_ack    = dbg_push && !rst;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (push_data),
        .dout (head),
        .full (full),
        .empty(empty),
        .level(level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            uart_data <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (pop) uart_data <= head;
        end
    end

    // SEND plus BYTE_CYCLES-1 WAIT cycles gives exactly one frame between pulses
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                state_n = empty ? IDLE : SEND;
                pop     = !empty;
            end
            SEND: begin
                state_n = WAIT;
                cnt_n   = RELOAD;
            end
            WAIT: begin
                state_n = (cnt != '0) ? WAIT : (empty ? IDLE : SEND);
                pop     = (cnt == '0) && !empty;
                cnt_n   = (cnt != '0) ? cnt - CW'(1) : cnt;
            end
            default: state_n = IDLE;
        endcase
    end

    assign uart_we = state == SEND;
    assign busy    = !empty || state != IDLE;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: table vectors, hand sequences and random traffic checked against
// a per-byte schedule model (pulse = max(arrival+1, previous pulse + frame)).
module tb_uart_tx_scheduler;
    localparam int DEPTH = 4;
    localparam int BC    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       core_we = 1'b0;
    logic [7:0] core_data = '0;
    logic       dbg_req = 1'b0;
    logic [7:0] dbg_data = '0;
    logic       core_stall;
    logic       dbg_ack;
    logic       uart_we;
    logic [7:0] uart_data;
    logic [2:0] level;
    logic       busy;

    uart_tx_scheduler #(
        .DEPTH(DEPTH),
        .BYTE_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .core_we   (core_we),
        .core_data (core_data),
        .core_stall(core_stall),
        .dbg_req   (dbg_req),
        .dbg_data  (dbg_data),
        .dbg_ack   (dbg_ack),
        .uart_we   (uart_we),
        .uart_data (uart_data),
        .level     (level),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] mq[$];
    int         ma[$];
    int         last_p;
    int         k;
    logic [7:0] last_d;

    typedef struct {
        logic       cw;
        logic [7:0] cd;
        logic       dr;
        logic [7:0] dd;
        logic [14:0] exp;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [14:0] ev(logic st, logic ack, logic we, logic [7:0] d, logic [2:0] lv, logic bz);
        return {st, ack, we, d, lv, bz};
    endfunction

    function automatic logic [14:0] outv();
        return {core_stall, dbg_ack, uart_we, uart_data, level, busy};
    endfunction

    function automatic logic [14:0] model_out(logic cw, logic dr);
        logic full;
        full = mq.size() == DEPTH;
        return {full, dr && !cw && !full, k == last_p, last_d, 3'(mq.size()),
                (mq.size() != 0) || (k <= last_p + BC - 1)};
    endfunction

    function automatic void model_edge(logic cw, logic [7:0] cd, logic dr, logic [7:0] dd);
        logic full;
        int   p;
        full = mq.size() == DEPTH;
        if (mq.size() != 0) begin
            p = (ma[0] + 1 > last_p + BC) ? ma[0] + 1 : last_p + BC;
            if (p <= k + 1) begin
                last_d = mq.pop_front();
                void'(ma.pop_front());
                last_p = k + 1;
            end
        end
        if (!full && (cw || dr)) begin
            mq.push_back(cw ? cd : dd);
            ma.push_back(k + 1);
        end
        k++;
    endfunction

    function automatic void model_reset();
        mq.delete();
        ma.delete();
        last_p = -100;
        last_d = '0;
        k = 0;
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(logic cw, logic [7:0] cd, logic dr, logic [7:0] dd);
        core_we = cw;
        core_data = cd;
        dbg_req = dr;
        dbg_data = dd;
        #1;
    endtask

    task automatic advance();
        model_edge(core_we, core_data, dbg_req, dbg_data);
        @(negedge clk);
    endtask

    // entered at a negedge; asserts reset mid-cycle and releases it one cycle later
    task automatic do_reset();
        rst = 1'b1;
        core_we = 1'b0;
        dbg_req = 1'b1;
        #1;
        check("reset_async", outv(), '0);
        @(negedge clk);
        #1;
        check("reset_held", outv(), '0);
        rst = 1'b0;
        dbg_req = 1'b0;
        model_reset();
    endtask

    task automatic run_model(string name, logic cw, logic [7:0] cd, logic dr, logic [7:0] dd);
        drive(cw, cd, dr, dd);
        check(name, outv(), model_out(cw, dr));
        advance();
    endtask

    initial begin
        logic       cw;
        logic       dr;
        logic       ch;
        logic       dh;
        logic [7:0] cd;
        logic [7:0] dd;
        logic [7:0] sent[$];
        logic [47:0] g;
        int         idx;

        tbl[0]  = '{1'b1, 8'h43, 1'b1, 8'h44, ev(0, 0, 0, 8'h00, 3'd0, 0)};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 8'h44, ev(0, 1, 0, 8'h00, 3'd1, 1)};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 8'h00, ev(0, 0, 1, 8'h43, 3'd1, 1)};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, ev(0, 0, 0, 8'h43, 3'd1, 1)};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, ev(0, 0, 0, 8'h43, 3'd1, 1)};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, ev(0, 0, 0, 8'h43, 3'd1, 1)};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 8'h00, ev(0, 0, 1, 8'h44, 3'd0, 1)};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, ev(0, 0, 0, 8'h44, 3'd0, 1)};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 8'h00, ev(0, 0, 0, 8'h44, 3'd0, 1)};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, ev(0, 0, 0, 8'h44, 3'd0, 1)};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 8'h00, ev(0, 0, 0, 8'h44, 3'd0, 0)};

        @(negedge clk);
        do_reset();

        // arbitration: core and debug together, core first
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].cw, tbl[i].cd, tbl[i].dr, tbl[i].dd);
            check($sformatf("arb_row%0d", i), outv(), tbl[i].exp);
            advance();
        end

        // reset in WAIT with three bytes still queued, then silence
        do_reset();
        for (int i = 0; i < 4; i++) run_model($sformatf("prefill%0d", i), 1'b1, 8'h50 + 8'(i), 1'b0, 8'h00);
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        check("pre_reset_level", {uart_we, level}, {1'b0, 3'd3});
        advance();
        do_reset();
        for (int i = 0; i < 10; i++) run_model($sformatf("post_reset%0d", i), 1'b0, 8'h00, 1'b0, 8'h00);

        // burst of six core writes with a held stalled store
        do_reset();
        idx = 0;
        for (int i = 0; i < 40; i++) begin
            cw = idx < 6;
            cd = 8'h30 + 8'(idx);
            drive(cw, cd, 1'b0, 8'h00);
            check($sformatf("burst%0d", i), outv(), model_out(cw, 1'b0));
            if (k == 5) check("full_stall", {core_stall, level}, {1'b1, 3'd4});
            if (k == 6) check("full_free", {core_stall, level}, {1'b0, 3'd3});
            if (k == 7) check("full_accept", {core_stall, level}, {1'b1, 3'd4});
            if (uart_we) sent.push_back(uart_data);
            if (cw && mq.size() != DEPTH) idx++;
            advance();
        end
        g = '0;
        foreach (sent[i]) g = {g[39:0], sent[i]};
        check("burst_count", 64'(sent.size()), 64'd6);
        check("burst_order", g, 48'h303132333435);

        // random traffic obeying the hold-until-accepted handshakes
        cw = 1'b0; dr = 1'b0; cd = '0; dd = '0;
        for (int i = 0; i < 600; i++) begin
            if (i % 200 == 199) begin
                do_reset();
                cw = 1'b0;
                dr = 1'b0;
            end
            drive(cw, cd, dr, dd);
            check($sformatf("rand%0d", i), outv(), model_out(cw, dr));
            ch = cw && mq.size() == DEPTH;
            dh = dr && (cw || mq.size() == DEPTH);
            advance();
            if (!ch) begin
                cw = $urandom_range(0, 2) == 0;
                cd = 8'($urandom);
            end
            if (!dh) begin
                dr = $urandom_range(0, 3) == 0;
                dd = 8'($urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
